// File: rtl/lcd_bus_driver_if.sv
// Processor-side word plus HD44780 pin bundle for lcd_bus_driver.
// The driver takes the master view; the processor/bench side takes the slave view.
interface lcd_bus_driver_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        lcd_blon_o;
  logic        busy_o;
  logic        init_done_o;

  modport master (
    input  lcd_word_i,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    output lcd_on_o, lcd_blon_o, busy_o, init_done_o
  );

  modport slave (
    output lcd_word_i,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
    input  lcd_on_o, lcd_blon_o, busy_o, init_done_o
  );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: runs the power-up init sequence, then turns
// each toggle of lcd_word_i[30] into one timed RS/DATA/EN write cycle.
module lcd_bus_driver #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lcd_bus_driver_if.master bus
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_EN_HI = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;

  localparam logic [19:0] C_PWRUP = 20'(T_PWRUP);
  localparam logic [19:0] C_SETUP = 20'(T_SETUP);
  localparam logic [19:0] C_EN    = 20'(T_EN);
  localparam logic [19:0] C_HOLD  = 20'(T_HOLD);
  localparam logic [19:0] C_CMD   = 20'(T_CMD);
  localparam logic [19:0] C_CLEAR = 20'(T_CLEAR);

  logic [2:0]  r_state, w_state_next;
  logic [19:0] r_cnt, w_cnt_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [7:0]  r_data, w_data_next;
  logic        r_rs, w_rs_next;
  logic        r_last_tog, w_tog_next;
  logic        r_done, w_done_next;
  logic        r_en, r_rw, r_on, r_blon, r_busy;
  logic        w_cnt_last, w_is_clear, w_req;
  logic [7:0]  w_init_byte;
  logic        w_unused_bits;

  assign w_unused_bits = ^{bus.lcd_word_i[28:10], bus.lcd_word_i[8]};

  // Each timed state loads its duration N and leaves when the count reaches 1,
  // so it occupies exactly N cycles.
  assign w_cnt_last = (r_cnt == 20'd1);
  assign w_is_clear = !r_rs && (r_data[7:2] == 6'd0) && (r_data[1:0] != 2'd0);
  assign w_req      = bus.lcd_word_i[30] ^ r_last_tog;

  always_comb begin
    w_init_byte = 8'h38;
    case (r_idx)
      2'd0: w_init_byte = 8'h38;
      2'd1: w_init_byte = 8'h0C;
      2'd2: w_init_byte = 8'h01;
      2'd3: w_init_byte = 8'h06;
      default: w_init_byte = 8'h38;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_data_next  = r_data;
    w_rs_next    = r_rs;
    w_tog_next   = r_last_tog;
    w_done_next  = r_done;
    case (r_state)
      S_PWRUP: begin
        if (w_cnt_last) begin
          w_state_next = S_LOAD;
          w_idx_next   = 2'd0;
        end else begin
          w_cnt_next = r_cnt - 20'd1;
        end
      end
      S_LOAD: begin
        w_data_next  = w_init_byte;
        w_rs_next    = 1'b0;
        w_state_next = S_SETUP;
        w_cnt_next   = C_SETUP;
      end
      S_SETUP: begin
        if (w_cnt_last) begin
          w_state_next = S_EN_HI;
          w_cnt_next   = C_EN;
        end else begin
          w_cnt_next = r_cnt - 20'd1;
        end
      end
      S_EN_HI: begin
        if (w_cnt_last) begin
          w_state_next = S_HOLD;
          w_cnt_next   = C_HOLD;
        end else begin
          w_cnt_next = r_cnt - 20'd1;
        end
      end
      S_HOLD: begin
        if (w_cnt_last) begin
          w_state_next = S_EXEC;
          w_cnt_next   = w_is_clear ? C_CLEAR : C_CMD;
        end else begin
          w_cnt_next = r_cnt - 20'd1;
        end
      end
      S_EXEC: begin
        if (!w_cnt_last) begin
          w_cnt_next = r_cnt - 20'd1;
        end else if (r_done) begin
          w_state_next = S_IDLE;
        end else if (r_idx != 2'd3) begin
          w_state_next = S_LOAD;
          w_idx_next   = r_idx + 2'd1;
        end else begin
          // Toggles seen during init are absorbed by resyncing here.
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
          w_tog_next   = bus.lcd_word_i[30];
        end
      end
      S_IDLE: begin
        if (w_req) begin
          w_data_next  = bus.lcd_word_i[7:0];
          w_rs_next    = bus.lcd_word_i[9];
          w_tog_next   = bus.lcd_word_i[30];
          w_state_next = S_SETUP;
          w_cnt_next   = C_SETUP;
        end
      end
      default: begin
        w_state_next = S_PWRUP;
        w_cnt_next   = C_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_PWRUP;
      r_cnt      <= C_PWRUP;
      r_idx      <= 2'd0;
      r_data     <= 8'h00;
      r_rs       <= 1'b0;
      r_last_tog <= 1'b0;
      r_done     <= 1'b0;
      r_en       <= 1'b0;
      r_rw       <= 1'b0;
      r_on       <= 1'b0;
      r_blon     <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_data     <= w_data_next;
      r_rs       <= w_rs_next;
      r_last_tog <= w_tog_next;
      r_done     <= w_done_next;
      // EN and busy follow the next state so they line up with the state register.
      r_en       <= (w_state_next == S_EN_HI);
      r_busy     <= (w_state_next != S_IDLE);
      r_rw       <= 1'b0;
      r_on       <= bus.lcd_word_i[31];
      r_blon     <= bus.lcd_word_i[29];
    end
  end

  assign bus.lcd_data_o  = r_data;
  assign bus.lcd_rs_o    = r_rs;
  assign bus.lcd_rw_o    = r_rw;
  assign bus.lcd_en_o    = r_en;
  assign bus.lcd_on_o    = r_on;
  assign bus.lcd_blon_o  = r_blon;
  assign bus.busy_o      = r_busy;
  assign bus.init_done_o = r_done;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: stimulus queues expected EN pulses and
// busy lengths; a monitor checks them as the DUT produces them.
module tb_lcd_bus_driver;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  lcd_bus_driver_if bus ();

  lcd_bus_driver #(
    .T_PWRUP(10), .T_SETUP(1), .T_EN(2), .T_HOLD(1), .T_CMD(5), .T_CLEAR(20)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         width;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   busy_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0, last_fall = 0, width = 0, blen = 0;
  bit   en_prev = 0, busy_prev = 0, have_cur = 0, counting = 0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (bus.lcd_en_o && !en_prev) begin
        width = 0;
        if (exp_q.size() == 0) begin
          flag("unexpected_en_pulse");
          have_cur = 0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1;
          if (cur.gap != 0) chk("en_gap", cyc - last_fall, cur.gap);
        end
      end
      if (bus.lcd_en_o) begin
        width++;
        if (have_cur) begin
          chk("en_data", bus.lcd_data_o, cur.data);
          chk("en_rs", bus.lcd_rs_o, cur.rs);
        end
      end
      if (!bus.lcd_en_o && en_prev) begin
        if (have_cur) begin
          $display("pulse data=%02h rs=%0b width=%0d", cur.data, cur.rs, width);
          chk("en_width", width, cur.width);
        end
        last_fall = cyc;
        have_cur  = 0;
      end
      if (bus.busy_o && !busy_prev && bus.init_done_o) begin
        counting = 1;
        blen     = 0;
      end
      if (counting && !bus.init_done_o) counting = 0;
      if (counting && bus.busy_o) blen++;
      if (counting && !bus.busy_o) begin
        counting = 0;
        if (busy_q.size() == 0) flag("unexpected_busy_run");
        else chk("busy_len", blen, busy_q.pop_front());
      end
      en_prev   = bus.lcd_en_o;
      busy_prev = bus.busy_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic [7:0] d, input logic rs, input int w, input int gap);
    exp_t e;
    e.data  = d;
    e.rs    = rs;
    e.width = w;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_exp(8'h38, 1'b0, 2, 0);
    push_exp(8'h0C, 1'b0, 2, 8);
    push_exp(8'h01, 1'b0, 2, 8);
    push_exp(8'h06, 1'b0, 2, 23);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int gap, input int w, input int blen_exp);
    push_exp(d, rs, w, gap);
    if (blen_exp > 0) busy_q.push_back(blen_exp);
    @(negedge clk_i);
    bus.lcd_word_i[9]   = rs;
    bus.lcd_word_i[7:0] = d;
    bus.lcd_word_i[30]  = ~bus.lcd_word_i[30];
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (bus.busy_o && k < 500);
    if (bus.busy_o) flag("idle_timeout");
  endtask

  task automatic run_init(input bit poke);
    int n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      n++;
      if (poke && n == 2) begin
        bus.lcd_word_i[31] = 1'b1;
        bus.lcd_word_i[29] = 1'b1;
        bus.lcd_word_i[30] = ~bus.lcd_word_i[30];
      end
      if (poke && n == 3) begin
        chk("on_follow", bus.lcd_on_o, 1'b1);
        chk("blon_follow", bus.lcd_blon_o, 1'b1);
      end
      if (poke && n == 30) bus.lcd_word_i[30] = ~bus.lcd_word_i[30];
      if (poke && n == 45) bus.lcd_word_i[30] = ~bus.lcd_word_i[30];
      if (bus.init_done_o) break;
    end
    $display("init done after %0d cycles", n);
    chk("init_cycles", n, 65);
    chk("busy_at_done", bus.busy_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, bus.lcd_data_o, 8'h00);
    chk({tag, "_rs"}, bus.lcd_rs_o, 1'b0);
    chk({tag, "_rw"}, bus.lcd_rw_o, 1'b0);
    chk({tag, "_en"}, bus.lcd_en_o, 1'b0);
    chk({tag, "_on"}, bus.lcd_on_o, 1'b0);
    chk({tag, "_blon"}, bus.lcd_blon_o, 1'b0);
    chk({tag, "_busy"}, bus.busy_o, 1'b1);
    chk({tag, "_done"}, bus.init_done_o, 1'b0);
  endtask

  initial begin
    int k;
    bus.lcd_word_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst0");
    push_init();
    rst_i = 1'b0;
    run_init(1'b1);
    repeat (10) @(negedge clk_i);
    chk("no_extra_init_pulse", exp_q.size(), 0);

    // character write; change inputs right after acceptance
    send(1'b1, 8'h41, 0, 2, 9);
    @(negedge clk_i);
    @(negedge clk_i);
    bus.lcd_word_i[7:0] = 8'hFF;
    bus.lcd_word_i[9]   = 1'b0;
    wait_idle();

    // clear command uses the long execution wait
    send(1'b0, 8'h01, 0, 2, 24);
    wait_idle();

    // one toggle while busy is served after a single idle cycle
    send(1'b1, 8'h43, 0, 2, 9);
    repeat (3) @(negedge clk_i);
    send(1'b0, 8'h42, 8, 2, 9);
    wait_idle();
    repeat (3) @(negedge clk_i);
    wait_idle();

    // two toggles while busy cancel
    send(1'b1, 8'h44, 0, 2, 9);
    repeat (2) @(negedge clk_i);
    bus.lcd_word_i[7:0] = 8'h99;
    bus.lcd_word_i[30]  = ~bus.lcd_word_i[30];
    @(negedge clk_i);
    bus.lcd_word_i[30]  = ~bus.lcd_word_i[30];
    wait_idle();
    repeat (20) @(negedge clk_i);
    chk("cancel_exp_left", exp_q.size(), 0);

    // reset while EN is high
    send(1'b1, 8'h55, 0, 1, 0);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!bus.lcd_en_o && k < 50);
    if (!bus.lcd_en_o) flag("en_timeout");
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("rst_mid");
    push_init();
    rst_i = 1'b0;
    run_init(1'b0);

    send(1'b0, 8'h80, 0, 2, 9);
    wait_idle();
    repeat (10) @(negedge clk_i);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("busy_q_empty", busy_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
